line_memory: RTL and testbench
==============================

LINE_MEMORY -- requirements
Module: line_memory

Interface
REQ-001 The block SHALL have parameter LATENCY, default 10, giving cycles from request acceptance to ack (legal range 1..255).
REQ-002 The block SHALL have parameter DEPTH_LINES, default 512, giving the number of 256-bit lines stored (power of two).
REQ-003 The block SHALL have port clk_i, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit; reset is asynchronous and active-high.
REQ-005 The block SHALL have port mem_enable_i, input, 1 bit, the request valid, held high by the requester until ack.
REQ-006 The block SHALL have port mem_write_i, input, 1 bit: 1 = line write, 0 = line read.
REQ-007 The block SHALL have port mem_addr_i, input, 32 bits, the byte address; bits [4:0] are ignored.
REQ-008 The block SHALL have port mem_data_i, input, 256 bits, the write line data.
REQ-009 The block SHALL have port mem_ack_o, output, 1 bit, a one-cycle completion pulse.
REQ-010 The block SHALL have port mem_data_o, output, 256 bits, the read line data, valid only while mem_ack_o is high.

Function
REQ-011 The line index SHALL be mem_addr_i[5+log2(DEPTH_LINES)-1:5]; higher address bits are ignored, so addresses wrap modulo DEPTH_LINES lines.
REQ-012 The FSM SHALL have three states: IDLE, BUSY and ACK.
REQ-013 In IDLE with mem_enable_i=1, the FSM SHALL latch the address, the write flag and the write data, clear the latency counter and enter BUSY.
REQ-014 In BUSY the counter SHALL increment each cycle; when it reaches LATENCY-1 the FSM SHALL enter ACK.
REQ-015 In ACK, mem_ack_o SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-016 The ACK pulse SHALL fall LATENCY+1 rising edges after the accepting edge; with LATENCY=1 the pulse is high in the second cycle after acceptance.
REQ-017 A write SHALL commit the latched data to the array on the edge entering ACK.
REQ-018 A read SHALL present the array line on mem_data_o during the ACK cycle; mem_data_o SHALL be 0 in all other cycles.
REQ-019 The latched address and data SHALL be used for the access; input changes during BUSY SHALL be ignored.
REQ-020 If mem_enable_i falls during BUSY, the FSM SHALL abort to IDLE: no write, no ack.
REQ-021 Requests SHALL NOT be accepted in the ACK cycle; the earliest new acceptance is the cycle after ACK, giving one mandatory idle cycle.
REQ-022 Only one request SHALL be outstanding at a time; there is no queueing.
REQ-023 A read immediately following a write to the same line SHALL return the newly written data.

Reset
REQ-024 Assertion of rst_i SHALL force IDLE, counter 0, mem_ack_o 0 and mem_data_o 0 immediately, without waiting for a clock edge.
REQ-025 Reset asserted during BUSY SHALL discard the request with no array write; array contents SHALL NOT be cleared by reset.
REQ-026 Statistics counters (when present) SHALL reset to 0.

Configuration
REQ-027 With LINE_MEMORY_STATS_EN defined, the block SHALL add outputs rd_count_o (32 bits) and wr_count_o (32 bits), each incrementing on every ACK of its type and wrapping at 2^32; aborted requests SHALL not be counted.
REQ-028 With LINE_MEMORY_STATS_EN undefined, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 The bench SHALL cover a write then read of the same line: write line 0xA5..A5 at address 0x40 with LATENCY=10, then read 0x40. Required: each ack falls 11 edges after acceptance, and the read returns 0xA5..A5.
REQ-030 The bench SHALL cover address aliasing: write pattern P to 0x5F, then read 0x40 and 0x40+512*32. Required: both reads return P (low-bit ignore and wrap).
REQ-031 The bench SHALL cover abort: drop mem_enable_i 3 cycles into a write of 0xFF..FF to line 3. Required: no ack, line 3 unchanged, and the next request is accepted normally.
REQ-032 The bench SHALL cover reset mid-access: assert rst_i 5 cycles into a write. Required: mem_ack_o=0 at once, the old line contents persist, and a read after reset returns the old data.
REQ-033 The bench SHALL cover back-to-back requests: hold mem_enable_i high across the ack. Required: the second request is accepted the cycle after ACK, and its ack is spaced LATENCY+2 cycles from the first.
REQ-034 With LINE_MEMORY_STATS_EN defined, the bench SHALL issue 3 reads, 2 writes and 1 aborted write. Required: rd_count_o=3 and wr_count_o=2.

Source files
------------

// File: rtl/line_memory.sv
// Line-granular memory model: 256-bit lines, fixed access latency, one request at a time.
// Define LINE_MEMORY_STATS_EN to add the rd_count_o / wr_count_o completion counters.
module line_memory #(
  parameter int unsigned LATENCY     = 10,
  parameter int unsigned DEPTH_LINES = 512
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         mem_enable_i,
  input  logic         mem_write_i,
  input  logic [31:0]  mem_addr_i,
  input  logic [255:0] mem_data_i,
  output logic         mem_ack_o,
  output logic [255:0] mem_data_o
`ifdef LINE_MEMORY_STATS_EN
  ,
  output logic [31:0]  rd_count_o,
  output logic [31:0]  wr_count_o
`endif
);

  localparam int unsigned IdxW    = $clog2(DEPTH_LINES);
  localparam logic [7:0]  LastCnt = 8'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StAck} state_e;

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q;
  logic            wr_q;
  logic [255:0]    data_q;
  logic            accept;
  logic            complete;
  logic            mem_we;

  logic [255:0]    mem_q [DEPTH_LINES];

  // Bits outside the line index are deliberately ignored (byte offset and wrap).
  logic unused_addr;
  assign unused_addr = ^{mem_addr_i[31:5+IdxW], mem_addr_i[4:0]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_enable_i) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        // A dropped enable wins even on the final count: nothing commits.
        if (!mem_enable_i) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == LastCnt) begin
          complete = 1'b1;
          cnt_d    = '0;
          state_d  = StAck;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  assign mem_we = complete & wr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request is captured once at acceptance so the requester may change inputs while busy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q  <= '0;
      wr_q   <= 1'b0;
      data_q <= '0;
    end else if (accept) begin
      idx_q  <= mem_addr_i[5 +: IdxW];
      wr_q   <= mem_write_i;
      data_q <= mem_data_i;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[idx_q] <= data_q;
    end
  end

  always_comb begin
    mem_ack_o  = (state_q == StAck);
    mem_data_o = '0;
    if ((state_q == StAck) && !wr_q) begin
      mem_data_o = mem_q[idx_q];
    end
  end

`ifdef LINE_MEMORY_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_count_o <= '0;
      wr_count_o <= '0;
    end else if (complete) begin
      if (wr_q) begin
        wr_count_o <= wr_count_o + 32'd1;
      end else begin
        rd_count_o <= rd_count_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_line_memory.sv
// Directed bench for line_memory: vector table for plain accesses plus abort, reset,
// back-to-back and (with LINE_MEMORY_STATS_EN) statistics sequences.
module tb_line_memory;

  localparam int Lat = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_enable;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic         mem_ack;
  logic [255:0] mem_rdata;
`ifdef LINE_MEMORY_STATS_EN
  logic [31:0]  rd_count;
  logic [31:0]  wr_count;
`endif

  int total = 0;
  int bad   = 0;

  line_memory #(
    .LATENCY     (Lat),
    .DEPTH_LINES (512)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .mem_enable_i (mem_enable),
    .mem_write_i  (mem_write),
    .mem_addr_i   (mem_addr),
    .mem_data_i   (mem_wdata),
    .mem_ack_o    (mem_ack),
    .mem_data_o   (mem_rdata)
`ifdef LINE_MEMORY_STATS_EN
    ,
    .rd_count_o   (rd_count),
    .wr_count_o   (wr_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
    logic [255:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request from an idle cycle; lat counts edges from acceptance to ack fall.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [255:0] d,
                        output int lat, output logic [255:0] rd, output logic clean);
    logic leak;
    mem_enable = 1'b1;
    mem_write  = wr;
    mem_addr   = addr;
    mem_wdata  = d;
    @(posedge clk); #1;
    mem_write  = ~wr;
    mem_addr   = ~addr;
    mem_wdata  = ~d;
    lat  = -1;
    rd   = '0;
    leak = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if (mem_ack) begin
        lat        = i + 1;
        rd         = mem_rdata;
        mem_enable = 1'b0;
        break;
      end
      if (mem_rdata !== '0) leak = 1'b1;
    end
    mem_enable = 1'b0;
    @(posedge clk); #1;
    clean = (lat > 0) && (mem_ack === 1'b0) && (mem_rdata === '0) && !leak;
  endtask

  // Write that is withdrawn three cycles after acceptance; reports any ack seen.
  task automatic do_abort(input logic [31:0] addr, input logic [255:0] d, output logic acked);
    acked      = 1'b0;
    mem_enable = 1'b1;
    mem_write  = 1'b1;
    mem_addr   = addr;
    mem_wdata  = d;
    @(posedge clk); #1;
    repeat (3) begin
      @(posedge clk); #1;
      if (mem_ack) acked = 1'b1;
    end
    mem_enable = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (mem_ack) acked = 1'b1;
    end
  endtask

  localparam logic [255:0] PA5  = {32{8'hA5}};
  localparam logic [255:0] PatP = {4{64'h0123_4567_89AB_CDEF}};
  localparam logic [255:0] PatQ = {16{16'h3C3C}};
  localparam logic [255:0] PatR = {32{8'h5A}};
  localparam logic [255:0] PatS = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] Ones = {256{1'b1}};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t         vecs [9];
    int           lat;
    logic [255:0] rd;
    logic         clean;
    logic         acked;
    int           t1;
    int           t2;
    int           nack;
    logic [255:0] d1;
    logic [255:0] d2;

    vecs[0] = '{wr: 1'b1, addr: 32'h0000_0040, data: PA5,  exp: '0};
    vecs[1] = '{wr: 1'b0, addr: 32'h0000_0040, data: '0,   exp: PA5};
    vecs[2] = '{wr: 1'b1, addr: 32'h0000_005F, data: PatP, exp: '0};
    vecs[3] = '{wr: 1'b0, addr: 32'h0000_0040, data: '0,   exp: PatP};
    vecs[4] = '{wr: 1'b0, addr: 32'h0000_4040, data: '0,   exp: PatP};
    vecs[5] = '{wr: 1'b1, addr: 32'h0000_0060, data: PatQ, exp: '0};
    vecs[6] = '{wr: 1'b1, addr: 32'hFFFF_FFE0, data: PatR, exp: '0};
    vecs[7] = '{wr: 1'b0, addr: 32'h0000_3FE0, data: '0,   exp: PatR};
    vecs[8] = '{wr: 1'b0, addr: 32'h0000_0060, data: '0,   exp: PatQ};

    rst        = 1'b1;
    mem_enable = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ack", 256'(mem_ack), 256'(0));
    check("reset_data", mem_rdata, '0);
`ifdef LINE_MEMORY_STATS_EN
    check("reset_rd_count", 256'(rd_count), 256'(0));
    check("reset_wr_count", 256'(wr_count), 256'(0));
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].data, lat, rd, clean);
      check($sformatf("vec%0d_latency", i), 256'(lat), 256'(Lat + 1));
      check($sformatf("vec%0d_data", i), rd, vecs[i].exp);
      check($sformatf("vec%0d_pulse", i), 256'(clean), 256'(1));
    end

    // Abort: line 3 keeps PatQ and the next request behaves normally.
    do_abort(32'h0000_0060, Ones, acked);
    check("abort_no_ack", 256'(acked), 256'(0));
    do_req(1'b0, 32'h0000_0060, '0, lat, rd, clean);
    check("abort_next_latency", 256'(lat), 256'(Lat + 1));
    check("abort_line_kept", rd, PatQ);

    // Reset five cycles into a write of line 3.
    mem_enable = 1'b1;
    mem_write  = 1'b1;
    mem_addr   = 32'h0000_0060;
    mem_wdata  = PatS;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_busy_ack", 256'(mem_ack), 256'(0));
    mem_enable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    do_req(1'b0, 32'h0000_0060, '0, lat, rd, clean);
    check("rst_busy_old_data", rd, PatQ);
    check("rst_busy_latency", 256'(lat), 256'(Lat + 1));

    // Reset during a read's ack cycle must clear the outputs without a clock edge.
    mem_enable = 1'b1;
    mem_write  = 1'b0;
    mem_addr   = 32'h0000_0040;
    nack       = 0;
    for (int i = 0; i < 40 && nack == 0; i++) begin
      @(posedge clk); #1;
      if (mem_ack) nack = 1;
    end
    check("rst_ack_seen", 256'(nack), 256'(1));
    check("rst_ack_data_before", mem_rdata, PatP);
    rst = 1'b1;
    #1;
    check("rst_ack_async_ack", 256'(mem_ack), 256'(0));
    check("rst_ack_async_data", mem_rdata, '0);
    mem_enable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back reads with enable held across the ack.
    mem_enable = 1'b1;
    mem_write  = 1'b0;
    mem_addr   = 32'h0000_0060;
    t1   = -1;
    t2   = -1;
    d1   = '0;
    d2   = '0;
    nack = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (mem_ack) begin
        nack++;
        if (nack == 1) begin
          t1 = i;
          d1 = mem_rdata;
        end else if (nack == 2) begin
          t2         = i;
          d2         = mem_rdata;
          mem_enable = 1'b0;
        end
      end
    end
    mem_enable = 1'b0;
    check("b2b_first_ack", 256'(t1), 256'(Lat + 1));
    check("b2b_spacing", 256'(t2 - t1), 256'(Lat + 2));
    check("b2b_ack_count", 256'(nack), 256'(2));
    check("b2b_data1", d1, PatQ);
    check("b2b_data2", d2, PatQ);

`ifdef LINE_MEMORY_STATS_EN
    rst = 1'b1;
    #1;
    check("stats_clear_rd", 256'(rd_count), 256'(0));
    check("stats_clear_wr", 256'(wr_count), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    do_req(1'b0, 32'h0000_0040, '0, lat, rd, clean);
    do_req(1'b1, 32'h0000_0080, PA5, lat, rd, clean);
    do_req(1'b0, 32'h0000_0080, '0, lat, rd, clean);
    do_abort(32'h0000_00A0, Ones, acked);
    do_req(1'b1, 32'h0000_00A0, PatR, lat, rd, clean);
    do_req(1'b0, 32'h0000_00A0, '0, lat, rd, clean);
    check("stats_last_read", rd, PatR);
    check("stats_rd_count", 256'(rd_count), 256'(3));
    check("stats_wr_count", 256'(wr_count), 256'(2));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
